load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane.sv | 49 ++++
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding and a funct3 legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StResp  = 2'd3
  } lsu_state_e;

  // Stores only have signed-width encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic for the load/store unit.
//   word_i   : word read from data memory
//   lo_i     : byte offset within the word (already aligned for H/W)
//   funct3_i : RV32I load/store funct3
//   wdata_i  : store data (low lanes used for SB/SH)
//   load_o   : extracted and sign/zero-extended load result
//   merge_o  : word_i with the addressed byte/halfword replaced by store data
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'h0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    case (funct3_i[1:0])
      2'b00:   merge_o[{lo_i, 3'b000} +: 8] = wdata_i[7:0];
      2'b01:   merge_o[{lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed data memory with a
// whole-word write enable. Sub-word stores are done as read-modify-write.
// Optional feature macro: LSU_ALIGN_CHECK_EN -- when defined, misaligned H/W
// requests fault; otherwise the address is rounded down to natural alignment.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   lsu_valid_i/ready_o : core-side request handshake
//   lsu_we_i            : 1 = store, 0 = load
//   lsu_funct3_i        : access size/signedness
//   lsu_addr_i          : byte address
//   lsu_wdata_i         : store data
//   lsu_rdata_o         : load result, valid while lsu_done_o
//   lsu_done_o          : one-cycle completion pulse
//   lsu_fault_o         : qualifies lsu_done_o, request was illegal
//   mem_we_o/addr_o/wd_o: data memory write enable, word index, write data
//   mem_rd_i            : combinational data memory read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_done_o,
  output logic        lsu_fault_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;

  logic        accept;
  logic        req_fault;
  logic        range_ok;
  logic [1:0]  req_lo;
  logic        req_is_sw;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  assign accept = lsu_valid_i && (state_q == StIdle);

  // Request decode: legality and aligned byte offset.
  always_comb begin
    range_ok = ({2'b00, lsu_addr_i[31:2]} < MEM_WORDS);
    req_lo   = lsu_addr_i[1:0];
    if (lsu_funct3_i[1:0] == 2'b01) req_lo[0] = 1'b0;
    if (lsu_funct3_i[1:0] == 2'b10) req_lo    = 2'b00;
`ifdef LSU_ALIGN_CHECK_EN
    req_fault = !f3_legal(lsu_we_i, lsu_funct3_i) || !range_ok ||
                (req_lo != lsu_addr_i[1:0]);
`else
    req_fault = !f3_legal(lsu_we_i, lsu_funct3_i) || !range_ok;
`endif
    req_is_sw = lsu_we_i && (lsu_funct3_i == F3_W);
  end

  lsu_lane u_lane (
    .word_i   (mem_rd_i),
    .lo_i     (lo_q),
    .funct3_i (f3_q),
    .wdata_i  (wdata_q),
    .load_o   (lane_load),
    .merge_o  (lane_merge)
  );

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lo_q       <= 2'b00;
      f3_q       <= 3'b000;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      fault_q    <= 1'b0;
      rdata_q    <= 32'h0;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      f3_q       <= f3_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_fault)      state_d = StResp;
          else if (req_is_sw) state_d = StWrite;
          else                state_d = StRead;
        end
      end
      StRead:  state_d = we_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values.
  always_comb begin
    lo_d       = lo_q;
    f3_d       = f3_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    fault_d    = fault_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          lo_d    = req_lo;
          f3_d    = lsu_funct3_i;
          we_d    = lsu_we_i;
          wdata_d = lsu_wdata_i;
          fault_d = req_fault;
          // Load result stays visible until the next load; stores/faults clear it.
          if (lsu_we_i || req_fault) rdata_d = 32'h0;
          if (!req_fault) mem_addr_d = {2'b00, lsu_addr_i[31:2]};
          if (!req_fault && req_is_sw) mem_wd_d = lsu_wdata_i;
        end
      end
      StRead: begin
        if (we_q) mem_wd_d = lane_merge;
        else      rdata_d  = lane_load;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; reset clears mem_we_o asynchronously.
  always_comb begin
    lsu_ready_o = (state_q == StIdle);
    lsu_done_o  = (state_q == StResp);
    lsu_fault_o = (state_q == StResp) && fault_q;
    mem_we_o    = (state_q == StWrite);
    lsu_rdata_o = rdata_q;
    mem_addr_o  = mem_addr_q;
    mem_wd_o    = mem_wd_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference model predicts
// each response, a monitor compares on every done pulse.
module tb_load_store_unit;

  localparam int unsigned MW = 64;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = 3'b000;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lsu_valid_i  (lsu_valid),
    .lsu_ready_o  (lsu_ready),
    .lsu_we_i     (lsu_we),
    .lsu_funct3_i (lsu_funct3),
    .lsu_addr_i   (lsu_addr),
    .lsu_wdata_i  (lsu_wdata),
    .lsu_rdata_o  (lsu_rdata),
    .lsu_done_o   (lsu_done),
    .lsu_fault_o  (lsu_fault),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd)
  );

  logic [31:0] mem     [MW];
  logic [31:0] ref_mem [MW];
  int          cyc = 0;
  int          we_cnt = 0;
  int          we_seen = 0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          nwe;
    int          acc_cyc;
  } exp_t;

  exp_t expq[$];
  exp_t me;

  assign mem_rd = (mem_addr < MW) ? mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_addr < MW) mem[mem_addr[5:0]] <= mem_wd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: byte-granular view of memory, applied in issue order.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    int     size, idx, off;
    bit     ok;
    longint v;
    logic [31:0] w;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ok   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    idx  = int'(addr >> 2);
    off  = int'(addr % 4);
    if (idx >= int'(MW)) ok = 1'b0;
    if (off % size != 0) begin
      if (ALIGN) ok = 1'b0;
      else off = off - off % size;
    end
    e.fault = !ok;
    e.nwe   = 0;
    e.rdata = 32'h0;
    if (!ok) begin
      e.lat = 1;
      return;
    end
    w = ref_mem[idx];
    if (!we) begin
      v = longint'(w >> (8 * off)) % (longint'(1) << (8 * size));
      if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      e.rdata = v[31:0];
      e.lat   = 2;
    end else begin
      for (int b = 0; b < size; b++) w[8 * (off + b) +: 8] = wd[8 * b +: 8];
      ref_mem[idx] = w;
      e.nwe = 1;
      e.lat = (size == 4) ? 2 : 3;
    end
  endtask

  // Called on a falling edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    exp_t e;
    int   t;
    t = 0;
    while (!lsu_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!lsu_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got ready=0 expected 1");
      return;
    end
    lsu_valid  = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wd;
    model(we, f3, addr, wd, e);
    e.acc_cyc = cyc + 1;
    expq.push_back(e);
    @(posedge clk);
    #1;
    lsu_valid = 1'b0;
    lsu_addr  = $urandom;
    t = 0;
    while (!lsu_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!lsu_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got ready=0 expected 1");
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && lsu_done) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        me = expq.pop_front();
        check("rdata", lsu_rdata, me.rdata);
        check("fault", {31'h0, lsu_fault}, {31'h0, me.fault});
        check("latency", 32'(cyc - me.acc_cyc + 1), 32'(me.lat));
        check("mem_we_pulses", 32'(we_cnt - we_seen), 32'(me.nwe));
        we_seen = we_cnt;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(MW); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'h80FF7F01;  ref_mem[5] = 32'h80FF7F01;
    mem[3] = 32'h11223344;  ref_mem[3] = 32'h11223344;

    #2;
    check("rst_ready", {31'h0, lsu_ready}, 32'h1);
    check("rst_done", {31'h0, lsu_done}, 32'h0);
    check("rst_rdata", lsu_rdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 3'b000, 32'h15, 32'h0);
    issue(1'b0, 3'b000, 32'h16, 32'h0);
    issue(1'b0, 3'b101, 32'h16, 32'h0);
    issue(1'b0, 3'b001, 32'h16, 32'h0);
    issue(1'b0, 3'b010, 32'h14, 32'h0);
    issue(1'b1, 3'b000, 32'h0E, 32'hAAAAAA55);
    check("sb_rmw_word3", mem[3], 32'h11553344);
    issue(1'b1, 3'b001, 32'h12, 32'h0000BEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b0, 3'b010, 32'h21, 32'h0);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b1, 3'b010, 32'h100, 32'h12345678);
    issue(1'b1, 3'b100, 32'h08, 32'h12345678);

    // Abort an SB during its READ cycle.
    lsu_valid  = 1'b1;
    lsu_we     = 1'b1;
    lsu_funct3 = 3'b000;
    lsu_addr   = 32'h1D;
    lsu_wdata  = 32'h000000C3;
    @(posedge clk);
    #1;
    lsu_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("abort_ready", {31'h0, lsu_ready}, 32'h1);
    check("abort_mem_we", {31'h0, mem_we}, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wd", mem_wd, 32'h0);
    check("abort_rdata", lsu_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_ready_after", {31'h0, lsu_ready}, 32'h1);
    check("abort_mem_word7", mem[7], ref_mem[7]);

    for (int n = 0; n < 300; n++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && f3 <= 3'd1) f3 = f3 | 3'b100;
      issue(1'($urandom), f3, 32'($urandom_range(0, 'h11F)), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(expq.size()), 32'h0);
    for (int i = 0; i < int'(MW); i++) check("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
